// File: rtl/mod_cnt_pkg.sv
// Shared types and constants for the cascaded modulo-N counter.
// Consumed by mod_n_digit and mod_n_cascade_counter.
package mod_cnt_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int MOD_DEFAULT    = 6;
    localparam int DIGITS_DEFAULT = 2;

    // Bit width needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_n_cascade_counter_digit.sv
// One modulo-MOD digit: counts up or down when stepped, loads with clamping,
// and reports whether it sits at the terminal value for the current direction.
module mod_n_digit
    import mod_cnt_pkg::*;
#(
    parameter  int MOD   = MOD_DEFAULT,
    localparam int WIDTH = clog2_min1(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             at_term,
    output logic             clamped
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    dir_t             dir_s;

    assign dir_s   = dir_t'(up_dn);
    assign clamped = load && (load_val > MAX_VAL);
    assign value   = value_q;

    // Terminal value depends on direction: MOD-1 when counting up, 0 when down.
    always_comb begin
        at_term = 1'b0;
        if (dir_s == DIR_UP) begin
            at_term = (value_q == MAX_VAL);
        end else begin
            at_term = (value_q == ZERO_VAL);
        end
    end

    // Next digit value; an out-of-range value (upset) is forced to 0 on a step.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = clamped ? MAX_VAL : load_val;
        end else if (step_in) begin
            if (value_q > MAX_VAL) begin
                value_d = ZERO_VAL;
            end else if (dir_s == DIR_UP) begin
                value_d = (value_q == MAX_VAL) ? ZERO_VAL : (value_q + ONE_VAL);
            end else begin
                value_d = (value_q == ZERO_VAL) ? MAX_VAL : (value_q - ONE_VAL);
            end
        end else begin
            value_d = value_q;
        end
    end

    // Digit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= ZERO_VAL;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/mod_n_cascade_counter.sv
// DIGITS cascaded modulo-MOD digits with up/down, load, terminal count and wrap.
// Optional step prescaler enabled by defining MODCNT_PRESCALE_EN.
module mod_n_cascade_counter
    import mod_cnt_pkg::*;
#(
    parameter  int MOD      = MOD_DEFAULT,
    parameter  int DIGITS   = DIGITS_DEFAULT,
    parameter  int PRESCALE = 4,
    localparam int WIDTH    = clog2_min1(MOD),
    localparam int CW       = DIGITS * WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          up_dn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          tc,
    output logic          wrap,
    output logic          load_err
);

    logic [DIGITS-1:0] at_term_s;
    logic [DIGITS-1:0] clamped_s;
    logic [DIGITS:0]   carry_s;
    logic              step_s;
    logic              wrap_q;
    logic              wrap_d;
    logic              load_err_q;
    logic              load_err_d;

`ifdef MODCNT_PRESCALE_EN
    localparam int            PW       = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ZERO = PW'(0);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign step_s = en && (presc_q == PRE_LAST);

    // Prescaler advances only on enabled cycles; a load restarts the division.
    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = PRE_ZERO;
        end else if (en) begin
            presc_d = (presc_q == PRE_LAST) ? PRE_ZERO : (presc_q + PRE_ONE);
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= PRE_ZERO;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    localparam int PRESCALE_UNUSED = PRESCALE;

    assign step_s = en;
`endif

    // carry_s[k] is the step seen by digit k: all lower digits are terminal.
    assign carry_s[0] = step_s;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign carry_s[k+1] = carry_s[k] & at_term_s[k];

        mod_n_digit #(
            .MOD (MOD)
        ) u_digit (
            .clk      (clk),
            .rst      (rst),
            .step_in  (carry_s[k]),
            .up_dn    (up_dn),
            .load     (load),
            .load_val (load_val[k*WIDTH +: WIDTH]),
            .value    (count[k*WIDTH +: WIDTH]),
            .at_term  (at_term_s[k]),
            .clamped  (clamped_s[k])
        );
    end

    assign tc       = carry_s[DIGITS] & ~load;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

    // Status pulses: tc is already forced low on load, so wrap never fires then.
    always_comb begin
        wrap_d     = tc;
        load_err_d = load & (|clamped_s);
    end

    // Status pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Randomised and directed bench for mod_n_cascade_counter (MOD=6, DIGITS=2).
// The reference treats the whole counter as one integer modulo MOD**DIGITS.
module tb_mod_n_cascade_counter;

    localparam int MOD      = 6;
    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int WIDTH    = 3;
    localparam int CW       = DIGITS * WIDTH;
    localparam int NSTATES  = MOD ** DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          up_dn;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          tc;
    logic          wrap;
    logic          load_err;

    int n_checks = 0;
    int n_fail   = 0;

    int m_total = 0;
    int m_presc = 0;
    bit m_wrap  = 1'b0;
    bit m_lerr  = 1'b0;
    bit last_tc = 1'b0;
    int wrap_seen;

    always #5 clk = ~clk;

    mod_n_cascade_counter #(
        .MOD      (MOD),
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] to_digits(input int t);
        logic [CW-1:0] r;
        int            p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[k*WIDTH +: WIDTH] = WIDTH'((t / p) % MOD);
            p = p * MOD;
        end
        return r;
    endfunction

    function automatic bit m_step(input bit e);
`ifdef MODCNT_PRESCALE_EN
        return e && (m_presc == PRESCALE - 1);
`else
        return e;
`endif
    endfunction

    // One clock: drive at negedge, check tc, advance model at posedge, check state at next negedge.
    task automatic cycle(input bit e, input bit u, input bit l, input logic [CW-1:0] lv);
        bit stp;
        bit tce;
        int lt;
        bit clampd;
        int p;
        int dv;
        en = e; up_dn = u; load = l; load_val = lv;
        #1;
        stp = m_step(e);
        tce = stp && !l && (u ? (m_total == NSTATES - 1) : (m_total == 0));
        last_tc = tc;
        check_eq("tc", tc, tce);
        lt = 0; clampd = 1'b0; p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            dv = int'(lv[k*WIDTH +: WIDTH]);
            if (dv > MOD - 1) begin
                dv = MOD - 1;
                clampd = 1'b1;
            end
            lt = lt + dv * p;
            p = p * MOD;
        end
        @(posedge clk);
        if (l) begin
            m_total = lt;
            m_lerr  = clampd;
            m_wrap  = 1'b0;
            m_presc = 0;
        end else begin
            if (stp) m_total = u ? (m_total + 1) % NSTATES : (m_total + NSTATES - 1) % NSTATES;
            m_wrap = tce;
            m_lerr = 1'b0;
            if (e) m_presc = (m_presc == PRESCALE - 1) ? 0 : m_presc + 1;
        end
        @(negedge clk);
        check_eq("count", count, to_digits(m_total));
        check_eq("wrap", wrap, m_wrap);
        check_eq("load_err", load_err, m_lerr);
        if (wrap) wrap_seen++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_count", count, 6'b000_000);
        check_eq("rst_wrap", wrap, 1'b0);
        check_eq("rst_lerr", load_err, 1'b0);
        rst = 1'b0;

        // Asynchronous reset in the middle of a cycle from {3,4}.
        cycle(1'b0, 1'b1, 1'b1, {3'd3, 3'd4});
        check_eq("load_34", count, 6'b011_100);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_count", count, 6'b000_000);
        check_eq("async_rst_wrap", wrap, 1'b0);
        check_eq("async_rst_lerr", load_err, 1'b0);
        m_total = 0; m_presc = 0; m_wrap = 1'b0; m_lerr = 1'b0;
        @(negedge clk);
        rst = 1'b0;

`ifndef MODCNT_PRESCALE_EN
        // Full up revolution: 36 steps from {0,0}.
        wrap_seen = 0;
        for (int i = 0; i < 36; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (i == 5) check_eq("seq_1_0", count, 6'b001_000);
        end
        check_eq("rev_count", count, 6'b000_000);
        check_eq("rev_wraps", wrap_seen, 1);

        // Down from {0,0}: terminal immediately, wraps to {5,5}.
        cycle(1'b1, 1'b0, 1'b0, '0);
        check_eq("down_tc", last_tc, 1'b1);
        check_eq("down_55", count, 6'b101_101);
        check_eq("down_wrap", wrap, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check_eq("down_54", count, 6'b101_100);
        check_eq("down_wrap_clr", wrap, 1'b0);
`endif

        // Load with clamping, then an in-range load.
        cycle(1'b0, 1'b1, 1'b1, {3'd2, 3'd7});
        check_eq("clamp_25", count, 6'b010_101);
        check_eq("clamp_err", load_err, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, {3'd1, 3'd3});
        check_eq("load_13", count, 6'b001_011);
        check_eq("load_noerr", load_err, 1'b0);

        // Load beats a terminal up step at {5,5}.
        cycle(1'b0, 1'b1, 1'b1, {3'd5, 3'd5});
        cycle(1'b1, 1'b1, 1'b1, {3'd1, 3'd2});
        check_eq("ld_pri_tc", last_tc, 1'b0);
        check_eq("ld_pri_wrap", wrap, 1'b0);
        check_eq("ld_pri_count", count, 6'b001_010);

`ifdef MODCNT_PRESCALE_EN
        cycle(1'b0, 1'b1, 1'b1, '0);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
        check_eq("pre_12", count, 6'b000_011);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, '0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        check_eq("pre_hold", count, 6'b000_011);
        cycle(1'b1, 1'b1, 1'b0, '0);
        check_eq("pre_step", count, 6'b000_100);
`endif

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), CW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
